ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop), validates them and queues accepted scan codes in a first-word
// fall-through FIFO.
//
// Ports:
//   clk        system clock
//   rest       synchronous, active-high reset
//   ps2_clk    PS/2 clock pin (asynchronous)
//   ps2_data   PS/2 data pin (asynchronous)
//   nextdata_n active-low pop request
//   data       scan code at the FIFO head (holds last value while empty)
//   ready      FIFO not empty
//   overflow   sticky: a good frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse: frame rejected or aborted by timeout
module ps2_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [TO_W-1:0]  C_TO      = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  C_TO_ONE  = TO_W'(1);

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [2:0]       r_clk_sync;
  logic [2:0]       r_dat_sync;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic [TO_W-1:0]  r_to_cnt;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_data;
  logic             r_ready;
  logic             r_overflow;
  logic             r_frame_err;

  logic             w_fall;
  logic             w_bit;
  logic             w_last;
  logic             w_frame_ok;
  logic             w_accept;
  logic             w_reject;
  logic             w_timeout;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [7:0]       w_rx_byte;
  logic [PTR_W-1:0] w_next_rptr;
  logic [CNT_W-1:0] w_next_count;
  logic [7:0]       w_next_head;

  // Frame decode: stage [2] is the older synchronized sample, so 1->0 is a falling edge.
  assign w_fall     = (r_clk_sync[2:1] == 2'b10);
  assign w_bit      = r_dat_sync[2];
  assign w_last     = w_fall && (r_bit_cnt == 4'd10);
  // After bits 0..9 are shifted in: [0]=start, [8:1]=data, [9]=parity; w_bit is the stop bit.
  assign w_frame_ok = (r_shift[0] == 1'b0) && (w_bit == 1'b1) &&
                      odd_parity_ok(r_shift[8:1], r_shift[9]);
  assign w_accept   = w_last && w_frame_ok;
  assign w_reject   = w_last && !w_frame_ok;
  assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == C_TO);
  assign w_rx_byte  = r_shift[8:1];

  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign w_full = (r_count == C_FULL);
  assign w_pop  = r_ready && !nextdata_n;
  assign w_push = w_accept && (!w_full || w_pop);
  assign w_drop = w_accept && w_full && !w_pop;

  // Synchronizers, bit counter, shift register and mid-frame timeout.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 3'b111;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 10'd0;
      r_to_cnt   <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[1:0], ps2_data};
      if (w_fall) begin
        r_to_cnt  <= '0;
        r_shift   <= {w_bit, r_shift[9:1]};
        r_bit_cnt <= (r_bit_cnt == 4'd10) ? 4'd0 : (r_bit_cnt + 4'd1);
      end else if (w_timeout) begin
        r_bit_cnt <= 4'd0;
        r_to_cnt  <= '0;
      end else if (r_bit_cnt == 4'd0) begin
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt  <= r_to_cnt + C_TO_ONE;
      end
    end
  end

  // Error pulse for a bad frame or an aborted partial frame.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_reject || w_timeout;
    end
  end

  // Next pointer/count and the head entry as it will look after this edge.
  always_comb begin
    w_next_rptr  = r_rptr;
    w_next_count = r_count;
    if (w_pop) begin
      w_next_rptr = r_rptr + C_PTR_ONE;
    end else begin
      w_next_rptr = r_rptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + C_CNT_ONE;
      2'b01:   w_next_count = r_count - C_CNT_ONE;
      default: w_next_count = r_count;
    endcase
    // The new byte becomes the head only when it lands on the next read slot.
    if (w_push && (r_wptr == w_next_rptr)) begin
      w_next_head = w_rx_byte;
    end else begin
      w_next_head = r_mem[w_next_rptr];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (!rest && w_push) begin
      r_mem[r_wptr] <= w_rx_byte;
    end
  end

  // FIFO pointers, occupancy and registered status/data outputs.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_data     <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      r_rptr  <= w_next_rptr;
      r_count <= w_next_count;
      r_ready <= (w_next_count != '0);
      // data keeps its last value once the FIFO drains.
      if (w_next_count != '0) begin
        r_data <= w_next_head;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_pop) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign ready     = r_ready;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rest, ps2_clk, ps2_data, nextdata_n;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int n_vec = 0;
  int n_miss = 0;
  int err_pulses = 0;
  int e0;
  logic [7:0] exp_q [$];

  ps2_rx_fifo #(.DEPTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rest(rest), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts frame_err cycles and checks every popped head against the scoreboard.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (rest === 1'b0 && ready === 1'b1 && nextdata_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL pop_unexpected: got %0h expected nothing", data);
      end else begin
        chk("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit; optionally pops in exactly the cycle the falling edge is detected.
  task automatic send_bit(input logic b, input logic pop_here);
    ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 if (pop_here) nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pop_stop);
    logic par;
    par = (~^d) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(1'b1, pop_stop);
    idle(4);
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && ready === 1'b1; k++) pop_one();
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rest = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    idle(3);
    chk("rst_data", {24'h0, data}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    rest = 1'b0;
    idle(5);

    // Single frame 0x1C, one pop, data held afterwards
    send_frame(8'h1C, 1'b0, 1'b0); exp_q.push_back(8'h1C);
    chk("s1_ready", {31'h0, ready}, 32'h1);
    chk("s1_data", {24'h0, data}, 32'h1C);
    pop_one(); idle(2);
    chk("s1_ready_after_pop", {31'h0, ready}, 32'h0);
    chk("s1_data_hold", {24'h0, data}, 32'h1C);

    // Two frames, ordering
    send_frame(8'hF0, 1'b0, 1'b0); exp_q.push_back(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0); exp_q.push_back(8'h1C);
    chk("s2_head", {24'h0, data}, 32'hF0);
    pop_one(); idle(2);
    chk("s2_second", {24'h0, data}, 32'h1C);
    pop_one(); idle(2);
    chk("s2_empty", {31'h0, ready}, 32'h0);

    // Overflow: nine frames into eight entries
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      if (i <= 8) exp_q.push_back(8'(i));
    end
    chk("s3_overflow", {31'h0, overflow}, 32'h1);
    chk("s3_head", {24'h0, data}, 32'h01);
    pop_one(); idle(2);
    chk("s3_overflow_clr", {31'h0, overflow}, 32'h0);
    chk("s3_head_after_pop", {24'h0, data}, 32'h02);
    drain();
    chk("s3_empty", {31'h0, ready}, 32'h0);
    chk("s3_q_empty", exp_q.size(), 32'h0);

    // Parity error, then a good frame
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("s4_err_pulse", err_pulses - e0, 32'h1);
    chk("s4_ready", {31'h0, ready}, 32'h0);
    send_frame(8'h32, 1'b0, 1'b0); exp_q.push_back(8'h32);
    chk("s4_data", {24'h0, data}, 32'h32);
    drain();

    // Timeout after five bits
    e0 = err_pulses;
    for (int i = 0; i < 5; i++) send_bit(1'(i == 2), 1'b0);
    idle(TO + 40);
    chk("s5_err_pulse", err_pulses - e0, 32'h1);
    chk("s5_bit_cnt", {28'h0, dut.r_bit_cnt}, 32'h0);
    chk("s5_ready", {31'h0, ready}, 32'h0);
    send_frame(8'h32, 1'b0, 1'b0); exp_q.push_back(8'h32);
    chk("s5_data", {24'h0, data}, 32'h32);
    drain();

    // Reset mid-frame: no error pulse, next frame clean
    e0 = err_pulses;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    rest = 1'b1; idle(2); rest = 1'b0; idle(2);
    chk("s6_no_err", err_pulses - e0, 32'h0);
    chk("s6_bit_cnt", {28'h0, dut.r_bit_cnt}, 32'h0);
    send_frame(8'h55, 1'b0, 1'b0); exp_q.push_back(8'h55);
    chk("s6_data", {24'h0, data}, 32'h55);
    drain();

    // Full FIFO, stop bit coincides with a pop
    for (int i = 0; i < 8; i++) begin
      send_frame(8'hA0 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'hA0 + 8'(i));
    end
    chk("s7_full_count", {28'h0, dut.r_count}, 32'h8);
    send_frame(8'hA8, 1'b0, 1'b1); exp_q.push_back(8'hA8);
    chk("s7_overflow", {31'h0, overflow}, 32'h0);
    chk("s7_count", {28'h0, dut.r_count}, 32'h8);
    chk("s7_head", {24'h0, data}, 32'hA1);
    drain();
    chk("s7_empty", {31'h0, ready}, 32'h0);
    chk("s7_q_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
